wb_arb2: RTL and testbench
==========================

WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 Parameter timeout_cycles, default 255: bus-cycle watchdog limit in clocks; 0 disables the watchdog.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 m0_adr_i / m1_adr_i  in  32  master address.
REQ-005 m0_dat_i / m1_dat_i  in  32  master write data.
REQ-006 m0_dat_o / m1_dat_o  out  32  read data; both carry s_dat_i unconditionally.
REQ-007 m0_sel_i / m1_sel_i  in  4  byte selects.
REQ-008 m0_we_i / m1_we_i  in  1  write enable.
REQ-009 m0_cyc_i / m1_cyc_i  in  1  cycle request; also the bus request.
REQ-010 m0_stb_i / m1_stb_i  in  1  strobe.
REQ-011 m0_ack_o / m1_ack_o  out  1  acknowledge; owner only.
REQ-012 m0_err_o / m1_err_o  out  1  error; owner only, includes watchdog error.
REQ-013 s_adr_o, s_dat_o, s_sel_o, s_we_o  out  32/32/4/1  owner's signals to the shared slave.
REQ-014 s_cyc_o, s_stb_o  out  1  slave cycle and strobe.
REQ-015 s_dat_i, s_ack_i, s_err_i  in  32/1/1  slave responses.
REQ-016 grant_o  out  2  one-hot current owner; 00 when no master owns the bus.
REQ-017 timeout_o  out  1  single-cycle pulse when the watchdog fires.

Function
REQ-018 The FSM SHALL have 2 states: IDLE and BUSY.
REQ-019 IDLE, no cyc_i high: stay IDLE, grant_o=00.
REQ-020 IDLE, exactly one cyc_i high: grant that master; BUSY next cycle.
REQ-021 IDLE, both cyc_i high: grant the master not granted most recently (round-robin via last-owner bit); BUSY next cycle.
REQ-022 Arbitration latency SHALL be exactly 1 cycle: the earliest s_stb_o is the cycle after request.
REQ-023 BUSY: s_adr_o/s_dat_o/s_sel_o/s_we_o = owner's inputs; s_cyc_o = owner cyc; s_stb_o = owner stb, except as in REQ-027.
REQ-024 BUSY: owner ack_o = s_ack_i and owner err_o = s_err_i, combinationally; the non-owner ack_o and err_o SHALL be 0.
REQ-025 Ownership SHALL be held while the owner's cyc_i is high, regardless of the other request; no preemption.
REQ-026 Owner cyc_i low in BUSY: go to IDLE next cycle, grant_o=00; s_cyc_o/s_stb_o=0 that cycle; the other master is arbitrated in IDLE (1 dead cycle between owners).
REQ-027 Watchdog: 8-bit counter; increments each BUSY cycle with owner stb high and s_ack_i=s_err_i=0; clears on ack, err, stb low, or IDLE. When count == timeout_cycles (nonzero): owner err_o=1, s_stb_o=0, timeout_o=1 for one cycle; counter clears.
REQ-028 s_ack_i and watchdog firing in the same cycle: ack wins; no err, no timeout_o.
REQ-029 In IDLE, s_cyc_o=s_stb_o=0; other slave outputs hold the last owner's values.

Reset
REQ-030 reset_n low SHALL immediately force: FSM IDLE, grant_o=00, last-owner=m1 (m0 favoured first), counter 0, all ack_o/err_o/timeout_o/s_cyc_o/s_stb_o 0. Mid-transaction reset abandons the cycle without ack.

Structure
REQ-031 The FSM state encoding and watchdog counter width SHALL reside in the shared package wb_pkg.
REQ-032 The watchdog SHALL be sub-module wb_watchdog (counter, compare, pulse); the arbiter FSM and muxes stay in wb_arb2.

Verification
REQ-033 m0 cyc/stb at cycle 0, read 0x4000_0010, slave acks at cycle 3 -> s_stb_o from cycle 1, m0_ack_o at 3, m1_ack_o 0, grant_o=01 for cycles 1-3.
REQ-034 Both request at cycle 0 after reset -> m0 granted; m0 releases at 4 -> grant_o 00 at 5, 10 at 6; next simultaneous request -> m0.
REQ-035 m1 owns; m0 requests mid-burst, 4 acks -> m1 keeps grant_o=10 through the last ack; m0 sees no ack.
REQ-036 timeout_cycles=4, slave never acks -> owner err_o and timeout_o high on the 5th stb cycle, s_stb_o 0 that cycle; timeout_cycles=0 -> no err after 1000 cycles.
REQ-037 s_ack_i on the exact firing cycle -> ack only, timeout_o 0.
REQ-038 reset_n low mid-BUSY -> same-cycle grant_o=00 and s_cyc_o=0; after release m0 wins the first contest.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding,
// owner identifiers and watchdog counter width.
package wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int WDOG_W = 8;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    function automatic logic [1:0] owner_grant(input logic owner);
        return (owner == OWNER_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog: counts unanswered strobe cycles and fires a one-cycle
// pulse when the count reaches the limit. A limit of 0 disables it.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int timeout_cycles = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic ack,
    input  logic err,
    output logic fire
);

    localparam logic [WDOG_W-1:0] LIMIT   = WDOG_W'(timeout_cycles);
    localparam logic              ENABLED = (timeout_cycles != 0);

    logic [WDOG_W-1:0] count;

    // An ack in the firing cycle wins, so the slave response is never overridden.
    assign fire = ENABLED && active && !ack && (count == LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!active || ack || err || fire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter in front of a single shared slave,
// with non-preemptive ownership and a per-cycle watchdog.
module wb_arb2
    import wb_pkg::*;
#(
    parameter int timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    arb_state_t state;
    logic       owner;
    logic       pick;
    logic       busy;
    logic       owner_cyc;
    logic       owner_stb;
    logic       wd_active;
    logic       wd_fire;

    // On a tie the master that did not own the bus last time gets it.
    assign pick = (m0_cyc_i && m1_cyc_i) ? ~owner : m1_cyc_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner   <= OWNER_M1;
            grant_o <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        state   <= BUSY;
                        owner   <= pick;
                        grant_o <= owner_grant(pick);
                    end
                end
                BUSY: begin
                    if (!owner_cyc) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

    assign busy      = (state == BUSY);
    assign owner_cyc = (owner == OWNER_M1) ? m1_cyc_i : m0_cyc_i;
    assign owner_stb = (owner == OWNER_M1) ? m1_stb_i : m0_stb_i;
    assign wd_active = busy && owner_cyc && owner_stb;

    wb_watchdog #(
        .timeout_cycles(timeout_cycles)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (wd_active),
        .ack     (s_ack_i),
        .err     (s_err_i),
        .fire    (wd_fire)
    );

    // The select only changes on a grant, so in IDLE the last owner's signals stay on the bus.
    assign s_adr_o = (owner == OWNER_M1) ? m1_adr_i : m0_adr_i;
    assign s_dat_o = (owner == OWNER_M1) ? m1_dat_i : m0_dat_i;
    assign s_sel_o = (owner == OWNER_M1) ? m1_sel_i : m0_sel_i;
    assign s_we_o  = (owner == OWNER_M1) ? m1_we_i  : m0_we_i;
    assign s_cyc_o = busy && owner_cyc;
    assign s_stb_o = wd_active && !wd_fire;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = busy && (owner == OWNER_M0) && s_ack_i;
    assign m1_ack_o = busy && (owner == OWNER_M1) && s_ack_i;
    assign m0_err_o = busy && (owner == OWNER_M0) && (s_err_i || wd_fire);
    assign m1_err_o = busy && (owner == OWNER_M1) && (s_err_i || wd_fire);

    assign timeout_o = wd_fire;

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: per-cycle vector table plus hand-written
// reset-mid-cycle and disabled-watchdog sequences.
module tb_wb_arb2;

    localparam logic [31:0] M0_ADR = 32'h4000_0010;
    localparam logic [31:0] M1_ADR = 32'h5000_0020;
    localparam logic [31:0] M0_DAT = 32'h1111_1111;
    localparam logic [31:0] M1_DAT = 32'h2222_2222;
    localparam logic [3:0]  M0_SEL = 4'hF;
    localparam logic [3:0]  M1_SEL = 4'h3;
    localparam logic        M0_WE  = 1'b0;
    localparam logic        M1_WE  = 1'b1;

    logic        clk;
    logic        reset_n;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    logic [31:0] z_m0_dat_o, z_m1_dat_o, z_s_adr_o, z_s_dat_o;
    logic [3:0]  z_s_sel_o;
    logic        z_m0_ack_o, z_m0_err_o, z_m1_ack_o, z_m1_err_o;
    logic        z_s_we_o, z_s_cyc_o, z_s_stb_o, z_timeout_o;
    logic [1:0]  z_grant_o;

    int checks   = 0;
    int failures = 0;

    wb_arb2 #(.timeout_cycles(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    wb_arb2 #(.timeout_cycles(0)) dut_z (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(z_m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(z_m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o),
        .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_sel_o(z_s_sel_o), .s_we_o(z_s_we_o),
        .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(z_grant_o), .timeout_o(z_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle of stimulus and the outputs expected during that cycle.
    typedef struct {
        logic       rst;
        logic       c0, s0, c1, s1, ack, err;
        logic [1:0] g;
        logic       scyc, sstb, a0, a1, e0, e1, to;
    } vec_t;

    vec_t vecs[$];

    // in  = {rst, m0 cyc, m0 stb, m1 cyc, m1 stb, s_ack, s_err}
    // out = {grant[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, timeout}
    function automatic vec_t v(input logic [6:0] in_bits, input logic [8:0] out_bits);
        vec_t t;
        {t.rst, t.c0, t.s0, t.c1, t.s1, t.ack, t.err} = in_bits;
        {t.g, t.scyc, t.sstb, t.a0, t.a1, t.e0, t.e1, t.to} = out_bits;
        return t;
    endfunction

    task automatic checkValue(input string name, input int step, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        @(posedge clk);
        #1;
        if (t.rst) begin
            {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i, s_err_i} = '0;
            reset_n = 1'b0;
            #2;
            reset_n = 1'b1;
        end
        m0_cyc_i = t.c0;
        m0_stb_i = t.s0;
        m1_cyc_i = t.c1;
        m1_stb_i = t.s1;
        s_ack_i  = t.ack;
        s_err_i  = t.err;
    endtask

    task automatic checkOutput(input int step, input vec_t t);
        checkValue("grant_o",   step, 128'(grant_o),   128'(t.g));
        checkValue("s_cyc_o",   step, 128'(s_cyc_o),   128'(t.scyc));
        checkValue("s_stb_o",   step, 128'(s_stb_o),   128'(t.sstb));
        checkValue("m0_ack_o",  step, 128'(m0_ack_o),  128'(t.a0));
        checkValue("m1_ack_o",  step, 128'(m1_ack_o),  128'(t.a1));
        checkValue("m0_err_o",  step, 128'(m0_err_o),  128'(t.e0));
        checkValue("m1_err_o",  step, 128'(m1_err_o),  128'(t.e1));
        checkValue("timeout_o", step, 128'(timeout_o), 128'(t.to));
        if (t.g == 2'b01)
            checkValue("slave_bus_m0", step, 128'({s_adr_o, s_dat_o, s_sel_o, s_we_o}),
                       128'({M0_ADR, M0_DAT, M0_SEL, M0_WE}));
        if (t.g == 2'b10)
            checkValue("slave_bus_m1", step, 128'({s_adr_o, s_dat_o, s_sel_o, s_we_o}),
                       128'({M1_ADR, M1_DAT, M1_SEL, M1_WE}));
    endtask

    initial begin
        int z_events;

        m0_adr_i = M0_ADR; m0_dat_i = M0_DAT; m0_sel_i = M0_SEL; m0_we_i = M0_WE;
        m1_adr_i = M1_ADR; m1_dat_i = M1_DAT; m1_sel_i = M1_SEL; m1_we_i = M1_WE;
        {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i, s_err_i} = '0;
        s_dat_i = 32'h0;
        reset_n = 1'b0;

        #3;
        checkValue("reset_grant",   -1, 128'(grant_o),   128'(2'b00));
        checkValue("reset_s_cyc",   -1, 128'(s_cyc_o),   128'(1'b0));
        checkValue("reset_timeout", -1, 128'(timeout_o), 128'(1'b0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single m0 read, slave acks on the fourth cycle.
        vecs.push_back(v(7'b1_11_00_00, 9'b00_00_00_00_0));
        vecs.push_back(v(7'b0_11_00_00, 9'b01_11_00_00_0));
        vecs.push_back(v(7'b0_11_00_00, 9'b01_11_00_00_0));
        vecs.push_back(v(7'b0_11_00_10, 9'b01_11_10_00_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b01_00_00_00_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b00_00_00_00_0));
        // Simultaneous requests after reset, dead cycle, then round-robin back to m0.
        vecs.push_back(v(7'b1_11_11_00, 9'b00_00_00_00_0));
        vecs.push_back(v(7'b0_11_11_00, 9'b01_11_00_00_0));
        vecs.push_back(v(7'b0_11_11_10, 9'b01_11_10_00_0));
        vecs.push_back(v(7'b0_11_11_00, 9'b01_11_00_00_0));
        vecs.push_back(v(7'b0_00_11_00, 9'b01_00_00_00_0));
        vecs.push_back(v(7'b0_00_11_00, 9'b00_00_00_00_0));
        vecs.push_back(v(7'b0_00_11_10, 9'b10_11_01_00_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b10_00_00_00_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b00_00_00_00_0));
        vecs.push_back(v(7'b0_11_11_00, 9'b00_00_00_00_0));
        vecs.push_back(v(7'b0_11_11_00, 9'b01_11_00_00_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b01_00_00_00_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b00_00_00_00_0));
        // m1 burst, m0 requests mid-burst without preempting; slave error to m1.
        vecs.push_back(v(7'b1_00_11_00, 9'b00_00_00_00_0));
        vecs.push_back(v(7'b0_00_11_10, 9'b10_11_01_00_0));
        vecs.push_back(v(7'b0_11_11_10, 9'b10_11_01_00_0));
        vecs.push_back(v(7'b0_11_11_10, 9'b10_11_01_00_0));
        vecs.push_back(v(7'b0_11_11_10, 9'b10_11_01_00_0));
        vecs.push_back(v(7'b0_11_11_01, 9'b10_11_00_01_0));
        vecs.push_back(v(7'b0_11_00_00, 9'b10_00_00_00_0));
        vecs.push_back(v(7'b0_11_00_00, 9'b00_00_00_00_0));
        vecs.push_back(v(7'b0_11_00_10, 9'b01_11_10_00_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b01_00_00_00_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b00_00_00_00_0));
        // Watchdog limit 4: fires on the 5th unanswered strobe, then ack beats a second firing.
        vecs.push_back(v(7'b1_11_00_00, 9'b00_00_00_00_0));
        for (int i = 0; i < 4; i++) vecs.push_back(v(7'b0_11_00_00, 9'b01_11_00_00_0));
        vecs.push_back(v(7'b0_11_00_00, 9'b01_10_00_10_1));
        for (int i = 0; i < 4; i++) vecs.push_back(v(7'b0_11_00_00, 9'b01_11_00_00_0));
        vecs.push_back(v(7'b0_11_00_10, 9'b01_11_10_00_0));
        vecs.push_back(v(7'b0_11_00_01, 9'b01_11_00_10_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b01_00_00_00_0));
        vecs.push_back(v(7'b0_00_00_00, 9'b00_00_00_00_0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(i, vecs[i]);
        end

        // Reset while m0 owns the bus; m0 was last owner, yet reset makes m0 favoured again.
        @(posedge clk);
        #1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        checkValue("pre_reset_grant", 100, 128'(grant_o), 128'(2'b01));
        checkValue("m0_dat_o", 100, 128'(m0_dat_o), 128'(32'hDEAD_BEEF));
        checkValue("m1_dat_o", 100, 128'(m1_dat_o), 128'(32'hDEAD_BEEF));
        #1 reset_n = 1'b0;
        #1;
        checkValue("mid_reset_grant", 101, 128'(grant_o),  128'(2'b00));
        checkValue("mid_reset_s_cyc", 101, 128'(s_cyc_o),  128'(1'b0));
        checkValue("mid_reset_m0_ack", 101, 128'(m0_ack_o), 128'(1'b0));
        #1 reset_n = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkValue("post_reset_contest", 102, 128'(grant_o), 128'(2'b01));

        // Watchdog disabled: a never-answered strobe must not error.
        @(posedge clk);
        #1;
        {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i, s_err_i} = '0;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        z_events = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (z_m0_err_o || z_timeout_o) z_events++;
        end
        checkValue("no_timeout_limit0", 200, 128'(z_events), 128'(0));
        checkValue("limit0_grant", 200, 128'(z_grant_o), 128'(2'b01));
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
